// File: rtl/bram_arbiter.sv
// rtl/bram_arbiter.sv - shares one single-port BRAM between a Wishbone slave and a valid/ready master
// Optional build macro: BRAM_ARB_FIXED_PRIO_EN (Wishbone always wins contested cycles; default is round-robin)
module bram_arbiter #(
  parameter int DELAYS = 10,
  parameter int ADDR_W = 32
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [ADDR_W-1:0] wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic              m_valid_i,
  input  logic [3:0]        m_we_i,
  input  logic [ADDR_W-1:0] m_adr_i,
  input  logic [31:0]       m_dat_i,
  output logic              m_ready_o,
  output logic [31:0]       m_dat_o,
  output logic              bram_en_o,
  output logic [3:0]        bram_we_o,
  output logic [ADDR_W-1:0] bram_adr_o,
  output logic [31:0]       bram_dat_o,
  input  logic [31:0]       bram_dat_i,
  output logic              busy_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_ACK   = 2'd3
  } state_t;

  localparam logic [15:0] DLY    = 16'(DELAYS);
  localparam logic        GNT_WB = 1'b0;
  localparam logic        GNT_M  = 1'b1;

  state_t              state_q, state_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                last_q, last_d;
  logic                gnt_q, gnt_d;
  logic                lock_q, lock_d;
  logic [ADDR_W-1:0]   adr_q, adr_d;
  logic [31:0]         dat_q, dat_d;
  logic [3:0]          we_q, we_d;

  logic                wb_req, m_req;
  logic                wb_req_eff, m_req_eff;
  logic                grant_valid, grant_sel;
  logic                wb_abort;
  logic                wait_done;
  logic                capture;

  // Raw requests, with the just-served requester masked for one IDLE cycle after its ack
  always_comb begin
    wb_req     = wbs_cyc_i & wbs_stb_i;
    m_req      = m_valid_i;
    wb_req_eff = wb_req & ~(lock_q & (gnt_q == GNT_WB));
    m_req_eff  = m_req  & ~(lock_q & (gnt_q == GNT_M));
    wb_abort   = (gnt_q == GNT_WB) & ~wbs_cyc_i;
    wait_done  = (cnt_q == DLY);
  end

  // Arbitration between the two eligible requesters
  always_comb begin
    grant_valid = wb_req_eff | m_req_eff;
    grant_sel   = GNT_WB;
`ifdef BRAM_ARB_FIXED_PRIO_EN
    // Wishbone wins whenever it asks; the master only gets idle Wishbone slots
    if (wb_req_eff) begin
      grant_sel = GNT_WB;
    end else begin
      grant_sel = GNT_M;
    end
`else
    // Contested cycles go to whoever was not granted last
    if (wb_req_eff && m_req_eff) begin
      grant_sel = (last_q == GNT_WB) ? GNT_M : GNT_WB;
    end else if (wb_req_eff) begin
      grant_sel = GNT_WB;
    end else begin
      grant_sel = GNT_M;
    end
`endif
  end

  // State register
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a Wishbone abort skips the remaining wait and the ack
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (grant_valid) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (wb_abort) begin
          state_d = S_IDLE;
        end else if (DLY == 16'd0) begin
          state_d = S_ACK;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wb_abort) begin
          state_d = S_IDLE;
        end else if (wait_done) begin
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Datapath next-state: request latch, wait counter, read capture, grant history
  always_comb begin
    adr_d   = adr_q;
    dat_d   = dat_q;
    we_d    = we_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    lock_d  = 1'b0;
    cnt_d   = 16'd0;
    rdata_d = rdata_q;
    capture = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (grant_valid) begin
          gnt_d = grant_sel;
`ifndef BRAM_ARB_FIXED_PRIO_EN
          last_d = grant_sel;
`endif
          if (grant_sel == GNT_WB) begin
            adr_d = wbs_adr_i;
            dat_d = wbs_dat_i;
            we_d  = wbs_sel_i & {4{wbs_we_i}};
          end else begin
            adr_d = m_adr_i;
            dat_d = m_dat_i;
            we_d  = m_we_i;
          end
        end
      end
      S_ISSUE: begin
        if (DLY == 16'd0) begin
          capture = 1'b1;
        end else if (!wb_abort) begin
          cnt_d = 16'd1;
        end
      end
      S_WAIT: begin
        if (wait_done) begin
          capture = 1'b1;
        end else if (!wb_abort) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_ACK: begin
        lock_d = 1'b1;
      end
      default: begin
        lock_d = 1'b0;
      end
    endcase

    if (capture) begin
      rdata_d = bram_dat_i;
    end
  end

  // Datapath registers
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      adr_q   <= '0;
      dat_q   <= '0;
      we_q    <= '0;
      gnt_q   <= GNT_WB;
      last_q  <= GNT_M;
      lock_q  <= 1'b0;
      cnt_q   <= 16'd0;
      rdata_q <= '0;
    end else begin
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      we_q    <= we_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      lock_q  <= lock_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Outputs decoded from state and latched request
  always_comb begin
    bram_en_o  = (state_q == S_ISSUE);
    bram_we_o  = (state_q == S_ISSUE) ? we_q : 4'd0;
    bram_adr_o = adr_q;
    bram_dat_o = dat_q;
    wbs_ack_o  = (state_q == S_ACK) & (gnt_q == GNT_WB);
    m_ready_o  = (state_q == S_ACK) & (gnt_q == GNT_M);
    wbs_dat_o  = rdata_q;
    m_dat_o    = rdata_q;
    busy_o     = (state_q != S_IDLE);
  end

endmodule

// File: tb/tb_bram_arbiter.sv
// tb/tb_bram_arbiter.sv - directed bench for bram_arbiter with a BRAM model
module tb_bram_arbiter;

  localparam int DLY = 10;

  logic        clk = 1'b0;
  logic        resetn;
  logic        wbs_cyc, wbs_stb, wbs_we;
  logic [3:0]  wbs_sel;
  logic [31:0] wbs_adr, wbs_dat_w;
  logic        wbs_ack;
  logic [31:0] wbs_dat_r;
  logic        m_valid;
  logic [3:0]  m_we;
  logic [31:0] m_adr, m_dat_w;
  logic        m_ready;
  logic [31:0] m_dat_r;
  logic        bram_en;
  logic [3:0]  bram_we;
  logic [31:0] bram_adr, bram_dat_w;
  logic [31:0] bram_dat_r = 32'h0;
  logic        busy;

  logic [31:0] mem [0:255] = '{default: 32'h0};

  int vectors = 0;
  int miscompares = 0;

  int          en_cnt, wb_ack_at, wb_ack_cnt, m_rdy_at, m_rdy_cnt, idle_at, we_nz_cnt;
  logic [3:0]  we_at_en;
  logic [31:0] adr_at_en, wb_dat_ack, m_dat_rdy;
  logic        snap_nz;

  bram_arbiter #(.DELAYS(DLY), .ADDR_W(32)) dut (
    .wb_clk_i   (clk),
    .wb_rst_ni  (resetn),
    .wbs_cyc_i  (wbs_cyc),
    .wbs_stb_i  (wbs_stb),
    .wbs_we_i   (wbs_we),
    .wbs_sel_i  (wbs_sel),
    .wbs_adr_i  (wbs_adr),
    .wbs_dat_i  (wbs_dat_w),
    .wbs_ack_o  (wbs_ack),
    .wbs_dat_o  (wbs_dat_r),
    .m_valid_i  (m_valid),
    .m_we_i     (m_we),
    .m_adr_i    (m_adr),
    .m_dat_i    (m_dat_w),
    .m_ready_o  (m_ready),
    .m_dat_o    (m_dat_r),
    .bram_en_o  (bram_en),
    .bram_we_o  (bram_we),
    .bram_adr_o (bram_adr),
    .bram_dat_o (bram_dat_w),
    .bram_dat_i (bram_dat_r),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  // Single-port BRAM model: registered read-before-write, byte-lane writes
  always @(posedge clk) begin
    if (bram_en) begin
      bram_dat_r <= mem[bram_adr[9:2]];
      for (int b = 0; b < 4; b++) begin
        if (bram_we[b]) mem[bram_adr[9:2]][8*b +: 8] <= bram_dat_w[8*b +: 8];
      end
    end
  end

  task automatic wb_request(input logic we, input logic [3:0] sel, input logic [31:0] adr, input logic [31:0] dat);
    wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = we; wbs_sel = sel; wbs_adr = adr; wbs_dat_w = dat;
  endtask

  task automatic m_request(input logic [3:0] we, input logic [31:0] adr, input logic [31:0] dat);
    m_valid = 1'b1; m_we = we; m_adr = adr; m_dat_w = dat;
  endtask

  task automatic do_reset();
    resetn = 1'b0; wbs_cyc = 1'b0; wbs_stb = 1'b0; m_valid = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  // Runs n cycles sampling at negedges; requesters drop after their own ack.
  // abort_at drops Wishbone cyc at that sample; rst_at pulses reset for one cycle.
  task automatic observe(input int n, input int abort_at, input int rst_at);
    en_cnt = 0; wb_ack_at = -1; wb_ack_cnt = 0; m_rdy_at = -1; m_rdy_cnt = 0;
    idle_at = -1; we_nz_cnt = 0; we_at_en = 4'hx; adr_at_en = 32'hx;
    wb_dat_ack = 32'hx; m_dat_rdy = 32'hx; snap_nz = 1'bx;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (bram_en) begin en_cnt++; we_at_en = bram_we; adr_at_en = bram_adr; end
      if (bram_we != 4'd0) we_nz_cnt++;
      if (wbs_ack) begin
        if (wb_ack_cnt == 0) begin wb_ack_at = i; wb_dat_ack = wbs_dat_r; end
        wb_ack_cnt++;
        wbs_cyc = 1'b0; wbs_stb = 1'b0;
      end
      if (m_ready) begin
        if (m_rdy_cnt == 0) begin m_rdy_at = i; m_dat_rdy = m_dat_r; end
        m_rdy_cnt++;
        m_valid = 1'b0;
      end
      if (!busy && idle_at < 0 && i > 1) idle_at = i;
      if (i == abort_at) begin wbs_cyc = 1'b0; wbs_stb = 1'b0; end
      if (i == rst_at + 1) begin
        snap_nz = wbs_ack | m_ready | bram_en | busy | (|bram_we) | (|bram_adr) |
                  (|bram_dat_w) | (|wbs_dat_r) | (|m_dat_r);
        resetn = 1'b1;
      end
      if (i == rst_at) begin
        resetn = 1'b0; wbs_cyc = 1'b0; wbs_stb = 1'b0; m_valid = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    vectors++; if (bram_en !== 1'b0) begin miscompares++; $display("FAIL rst_en got=%b exp=0", bram_en); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got=%b exp=0", busy); end
    vectors++; if ({wbs_ack, m_ready} !== 2'b00) begin miscompares++; $display("FAIL rst_ack got=%b exp=00", {wbs_ack, m_ready}); end
    vectors++; if (wbs_dat_r !== 32'h0) begin miscompares++; $display("FAIL rst_dat got=%h exp=0", wbs_dat_r); end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_wb_write();
    wb_request(1'b1, 4'hF, 32'h3800_0010, 32'hDEAD_BEEF);
    observe(20, -1, -1);
    vectors++; if (en_cnt !== 1) begin miscompares++; $display("FAIL wr_en_cnt got=%0d exp=1", en_cnt); end
    vectors++; if (we_at_en !== 4'hF) begin miscompares++; $display("FAIL wr_we got=%h exp=f", we_at_en); end
    vectors++; if (adr_at_en !== 32'h3800_0010) begin miscompares++; $display("FAIL wr_adr got=%h exp=38000010", adr_at_en); end
    vectors++; if (wb_ack_at !== DLY + 2) begin miscompares++; $display("FAIL wr_ack_at got=%0d exp=%0d", wb_ack_at, DLY + 2); end
    vectors++; if (wb_ack_cnt !== 1 || m_rdy_cnt !== 0) begin miscompares++; $display("FAIL wr_ack_cnt got=%0d/%0d exp=1/0", wb_ack_cnt, m_rdy_cnt); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL wr_busy_after got=%b exp=0", busy); end
    vectors++; if (mem[4] !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL wr_mem got=%h exp=deadbeef", mem[4]); end
  endtask

  task automatic test_wb_read();
    wb_request(1'b0, 4'hF, 32'h3800_0010, 32'h1111_1111);
    observe(20, -1, -1);
    vectors++; if (wb_dat_ack !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL rd_dat got=%h exp=deadbeef", wb_dat_ack); end
    vectors++; if (we_nz_cnt !== 0) begin miscompares++; $display("FAIL rd_we_cycles got=%0d exp=0", we_nz_cnt); end
    vectors++; if (wb_ack_at !== DLY + 2) begin miscompares++; $display("FAIL rd_ack_at got=%0d exp=%0d", wb_ack_at, DLY + 2); end
    vectors++; if (mem[4] !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL rd_mem_kept got=%h exp=deadbeef", mem[4]); end
  endtask

  task automatic test_sec_write();
    m_request(4'h3, 32'h0000_0020, 32'h1234_5678);
    observe(20, -1, -1);
    vectors++; if (we_at_en !== 4'h3) begin miscompares++; $display("FAIL sw_we got=%h exp=3", we_at_en); end
    vectors++; if (m_rdy_at !== DLY + 2 || wb_ack_cnt !== 0) begin miscompares++; $display("FAIL sw_ready got=%0d/%0d exp=%0d/0", m_rdy_at, wb_ack_cnt, DLY + 2); end
    wb_request(1'b0, 4'hF, 32'h0000_0020, 32'h0);
    observe(20, -1, -1);
    vectors++; if (wb_dat_ack !== 32'h0000_5678) begin miscompares++; $display("FAIL sw_readback got=%h exp=00005678", wb_dat_ack); end
  endtask

  task automatic test_contested();
    do_reset();
    for (int r = 0; r < 2; r++) begin
      wb_request(1'b0, 4'hF, 32'h3800_0010, 32'h0);
      m_request(4'h0, 32'h0000_0020, 32'h0);
      observe(40, -1, -1);
      vectors++; if (wb_ack_at !== DLY + 2) begin miscompares++; $display("FAIL ct%0d_wb_at got=%0d exp=%0d", r, wb_ack_at, DLY + 2); end
      vectors++; if (m_rdy_at !== 2 * DLY + 5) begin miscompares++; $display("FAIL ct%0d_m_at got=%0d exp=%0d", r, m_rdy_at, 2 * DLY + 5); end
      vectors++; if (m_dat_rdy !== 32'h0000_5678) begin miscompares++; $display("FAIL ct%0d_m_dat got=%h exp=00005678", r, m_dat_rdy); end
      vectors++; if (en_cnt !== 2) begin miscompares++; $display("FAIL ct%0d_en_cnt got=%0d exp=2", r, en_cnt); end
    end
  endtask

  task automatic test_abort();
    wb_request(1'b1, 4'hF, 32'h3800_0030, 32'hCAFE_F00D);
    observe(20, 4, -1);
    vectors++; if (wb_ack_cnt !== 0) begin miscompares++; $display("FAIL ab_ack got=%0d exp=0", wb_ack_cnt); end
    vectors++; if (en_cnt !== 1) begin miscompares++; $display("FAIL ab_en_cnt got=%0d exp=1", en_cnt); end
    vectors++; if (mem[12] !== 32'hCAFE_F00D) begin miscompares++; $display("FAIL ab_mem got=%h exp=cafef00d", mem[12]); end
    vectors++; if (idle_at < 2 || idle_at > DLY + 2) begin miscompares++; $display("FAIL ab_idle_at got=%0d exp<=%0d", idle_at, DLY + 2); end
  endtask

  task automatic test_reset_mid();
    wb_request(1'b0, 4'hF, 32'h3800_0010, 32'h0);
    observe(20, -1, 5);
    vectors++; if (snap_nz !== 1'b0) begin miscompares++; $display("FAIL rm_outputs got=%b exp=0", snap_nz); end
    vectors++; if (wb_ack_cnt !== 0) begin miscompares++; $display("FAIL rm_ack got=%0d exp=0", wb_ack_cnt); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rm_busy got=%b exp=0", busy); end
  endtask

`ifdef BRAM_ARB_FIXED_PRIO_EN
  task automatic test_fixed_prio();
    do_reset();
    for (int r = 0; r < 2; r++) begin
      wb_request(1'b0, 4'hF, 32'h3800_0010, 32'h0);
      m_request(4'h0, 32'h0000_0020, 32'h0);
      observe(40, -1, -1);
      vectors++; if (wb_ack_at !== DLY + 2) begin miscompares++; $display("FAIL fp%0d_wb_at got=%0d exp=%0d", r, wb_ack_at, DLY + 2); end
    end
  endtask
`endif

  initial begin
    resetn = 1'b0;
    wbs_cyc = 1'b0; wbs_stb = 1'b0; wbs_we = 1'b0; wbs_sel = 4'h0; wbs_adr = 32'h0; wbs_dat_w = 32'h0;
    m_valid = 1'b0; m_we = 4'h0; m_adr = 32'h0; m_dat_w = 32'h0;
    test_reset();
    test_wb_write();
    test_wb_read();
    test_sec_write();
    test_contested();
    test_abort();
    test_reset_mid();
`ifdef BRAM_ARB_FIXED_PRIO_EN
    test_fixed_prio();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bram_arbiter.md
Name: bram_arbiter

Overview:
- Shares the single-port user BRAM (32-bit data, 4 byte-lane write enables) between two requesters:
  - the Wishbone slave port (firmware loads and stores);
  - a secondary master port (user-side engine or DMA, valid/ready handshake).
- Arbitrates between them, drives exactly one BRAM enable cycle per access, then waits a fixed access delay.
- Registers read data and returns one acknowledge pulse to the granted requester.
- Sits between the user-project Wishbone interface and the bram instance in user_proj_example.

Parameters:
DELAYS, 10, BRAM access wait cycles between the issue cycle and the ack cycle (0 allowed; max 65535)
ADDR_W, 32, address width passed through to the BRAM A0 port

Ports:
wb_clk_i  in  1  single clock for all logic
wb_rst_ni  in  1  synchronous, active-low reset
wbs_cyc_i  in  1  Wishbone cycle
wbs_stb_i  in  1  Wishbone strobe
wbs_we_i  in  1  Wishbone write
wbs_sel_i  in  4  Wishbone byte selects
wbs_adr_i  in  ADDR_W  Wishbone address
wbs_dat_i  in  32  Wishbone write data
wbs_ack_o  out  1  Wishbone acknowledge (1-cycle pulse)
wbs_dat_o  out  32  Wishbone read data
m_valid_i  in  1  secondary request valid
m_we_i  in  4  secondary byte write enables (0 = read)
m_adr_i  in  ADDR_W  secondary address
m_dat_i  in  32  secondary write data
m_ready_o  out  1  secondary completion (1-cycle pulse)
m_dat_o  out  32  secondary read data
bram_en_o  out  1  BRAM EN0
bram_we_o  out  4  BRAM WE0
bram_adr_o  out  ADDR_W  BRAM A0
bram_dat_o  out  32  BRAM Di0
bram_dat_i  in  32  BRAM Do0
busy_o  out  1  high in any state other than IDLE

Behaviour:
Reset values (wb_rst_ni low at a clock edge):
- state=IDLE; all outputs 0; rdata_q=0; delay counter=0; last_grant=secondary.
- Consequence: the first contested grant goes to Wishbone.

Request definitions:
- Wishbone request: wbs_cyc_i & wbs_stb_i.
- Wishbone write mask: wbs_sel_i & {4{wbs_we_i}}.
- Secondary request: m_valid_i.

IDLE:
- Sample both requests at each edge.
- Exactly one requesting: grant it.
- Both requesting: grant the one not in last_grant (round-robin), then update last_grant.
- On grant: latch address, write data, byte mask and requester id into registers; go to ISSUE.

ISSUE (1 cycle):
- bram_en_o=1; bram_we_o, bram_adr_o, bram_dat_o driven from the latched registers.
- In every other state bram_en_o=0 and bram_we_o=0.
- Next state: WAIT if DELAYS>0, else ACK.

WAIT:
- Counter (16-bit) counts 1..DELAYS and clears on exit.
- Do0 is captured into rdata_q on the edge leaving the last WAIT cycle. For DELAYS=0 it is captured on the edge leaving ISSUE.
- Captured for writes as well; the value is don't-care for writes.

ACK (1 cycle):
- Pulse wbs_ack_o or m_ready_o for the granted requester only; then return to IDLE.
- Latency: request seen at edge N -> ack/ready high during cycle N+2+DELAYS.
- wbs_dat_o and m_dat_o both show rdata_q. The value is valid in the ACK cycle and held until the next capture.

Re-acquisition:
- The requester must drop its request, or present a new one, after the ack.
- The IDLE entered after ACK does not re-grant the same still-asserted request in that cycle: a one-cycle lockout prevents a double access. A new grant is possible one cycle later.

Wishbone abort:
- If wbs_cyc_i drops during ISSUE or WAIT, the BRAM access still completes (a write is already committed).
- wbs_ack_o is suppressed; the FSM goes to IDLE.

Other rules:
- Secondary requests cannot abort; m_valid_i must be held until m_ready_o.
- Reset mid-access: immediate return to IDLE with all outputs 0; no ack is ever issued for the interrupted access.
- Inputs of the ungranted requester are ignored until the next IDLE.

Optional Feature:
Macro BRAM_ARB_FIXED_PRIO_EN:
- Defined: Wishbone always wins a contested IDLE cycle; last_grant is unused. The secondary port is only served when Wishbone is idle.
- Undefined (default): round-robin as above.

Test Plan:
- DELAYS=10, WB write 0xDEADBEEF to 0x3800_0010, sel=0xF -> bram_en_o high for exactly 1 cycle with we=0xF; wbs_ack_o high in cycle N+12; busy_o low after.
- WB read of 0x3800_0010 after that write -> wbs_dat_o=0xDEADBEEF in the ack cycle; bram_we_o=0 throughout.
- WB and secondary request in the same cycle, right after reset, and hold -> WB served first (ack at N+12). Secondary ready 13 cycles later. A third contested round goes to WB.
- Secondary write 0x12345678 with m_we_i=0x3 to 0x20 (word initially 0) -> bram_we_o=0x3; subsequent WB read returns 0x00005678.
- WB cyc dropped 3 cycles into WAIT -> no wbs_ack_o, write still performed once, FSM IDLE by cycle N+12.
- Reset low for 1 cycle mid-WAIT -> next cycle all outputs 0, no ack. With BRAM_ARB_FIXED_PRIO_EN, two back-to-back contested rounds both grant WB.
